hazard_manager: RTL

- Parametrised successor to the fixed two-instance barrel plus collision arrangement.
- Owns N_SLOTS barrel slots, a periodic spawn scheduler, and per-frame motion with wall-bounce and floor-drop.
- Tests every active slot against the player box, and owns the lives counter with an invulnerability window and game-over latch.
- Sits between the player module and color_mapper; drives slot positions, active mask, lives and collision flags.

---
 rtl/hazard_pkg.sv | 45 ++++
 rtl/hazard_slot.sv | 89 ++++++++
 rtl/hazard_manager.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types, widths and a helper for the barrel hazard block.
//   slot_dir_t : horizontal travel direction of a barrel slot
//   slot_t     : packed per-slot state {x, y, dir, active}
//   dmg_state_t: damage/lives controller state
//   axis_near  : strict one-axis overlap test of two equal boxes
package hazard_pkg;

  localparam int COORD_W = 10;
  localparam int LIVES_W = 3;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } slot_dir_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    slot_dir_t          dir;
    logic               active;
  } slot_t;

  typedef enum logic [1:0] {
    DMG_ARMED  = 2'd0,
    DMG_IMMUNE = 2'd1,
    DMG_OVER   = 2'd2
  } dmg_state_t;

  localparam int XW = COORD_W + 1;

  // True when |a-b| < 2*half_box; the difference is taken in 11-bit signed
  // arithmetic so screen coordinates never wrap.
  function automatic logic axis_near(input logic [COORD_W-1:0] a,
                                     input logic [COORD_W-1:0] b,
                                     input int unsigned        half_box);
    logic signed [COORD_W:0] diff;
    logic        [COORD_W:0] mag;
    logic        [COORD_W:0] thr;
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    mag  = diff[COORD_W] ? -diff : diff;
    thr  = XW'(2 * half_box);
    return (mag < thr);
  endfunction

endpackage

// File: rtl/hazard_slot.sv
// hazard_slot: one barrel slot - horizontal motion, wall bounce with floor
// drop, despawn past the bottom, and loading at the spawn point.
//   clk        in  system clock
//   reset      in  synchronous clear (Reset or game re-arm)
//   step       in  frame step enable (frame tick while the game runs)
//   spawn_load in  load this slot at the spawn point and mark it active
//   x, y       out slot centre
//   active     out slot valid
module hazard_slot
  import hazard_pkg::*;
#(
  parameter int SPAWN_X    = 100,
  parameter int SPAWN_Y    = 60,
  parameter int SPEED      = 2,
  parameter int X_MIN      = 16,
  parameter int X_MAX      = 623,
  parameter int FLOOR_STEP = 64,
  parameter int Y_MAX      = 460
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step,
  input  logic               spawn_load,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               active
);

  localparam slot_t SPAWN_SLOT = '{x: COORD_W'(SPAWN_X), y: COORD_W'(SPAWN_Y),
                                   dir: DIR_RIGHT, active: 1'b0};

  slot_t          slot_r;
  slot_t          slot_next;
  logic [XW-1:0]  x_fwd;
  logic [XW-1:0]  y_drop;
  logic [XW-1:0]  y_new;

  // Next slot state: spawn load, or one frame of motion with bounce/despawn.
  always_comb begin
    slot_next = slot_r;
    x_fwd     = {1'b0, slot_r.x} + XW'(SPEED);
    y_drop    = {1'b0, slot_r.y} + XW'(FLOOR_STEP);
    y_new     = {1'b0, slot_r.y};
    if (spawn_load) begin
      slot_next        = SPAWN_SLOT;
      slot_next.active = 1'b1;
    end else if (step && slot_r.active) begin
      if (slot_r.dir == DIR_RIGHT) begin
        if (x_fwd > XW'(X_MAX)) begin
          slot_next.x   = COORD_W'(X_MAX);
          slot_next.dir = DIR_LEFT;
          y_new         = y_drop;
        end else begin
          slot_next.x = x_fwd[COORD_W-1:0];
        end
      end else begin
        if ({1'b0, slot_r.x} < XW'(X_MIN + SPEED)) begin
          slot_next.x   = COORD_W'(X_MIN);
          slot_next.dir = DIR_RIGHT;
          y_new         = y_drop;
        end else begin
          slot_next.x = slot_r.x - COORD_W'(SPEED);
        end
      end
      // Dropping past the bottom frees the slot and parks it at spawn.
      if (y_new >= XW'(Y_MAX)) begin
        slot_next = SPAWN_SLOT;
      end else begin
        slot_next.y = y_new[COORD_W-1:0];
      end
    end else begin
      slot_next = slot_r;
    end
  end

  // Slot state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_r <= SPAWN_SLOT;
    end else begin
      slot_r <= slot_next;
    end
  end

  assign x      = slot_r.x;
  assign y      = slot_r.y;
  assign active = slot_r.active;

endmodule

// File: rtl/hazard_manager.sv
// hazard_manager: N_SLOTS barrel hazards with periodic spawning, per-frame
// motion, player collision, lives with an invulnerability window and a
// game-over latch.
//   Clk, Reset         clock and synchronous active-high reset
//   frame_tick         one-cycle pulse per frame; all game state steps on it
//   restart            re-arms the game while game_over is set
//   PlayerX, PlayerY   player centre
//   SlotX, SlotY       packed slot centres, slot 0 in the LSBs
//   active             slot valid mask
//   lives              remaining lives
//   colliding          registered: any active slot overlaps the player
//   hit                one-cycle pulse when a life is lost
//   invuln             immunity window running
//   game_over          sticky until restart/Reset
//   spawn_overflow     sticky until Reset: a spawn found no free slot
module hazard_manager
  import hazard_pkg::*;
#(
  parameter int N_SLOTS       = 4,
  parameter int SPAWN_PERIOD  = 300,
  parameter int SPAWN_X       = 100,
  parameter int SPAWN_Y       = 60,
  parameter int SPEED         = 2,
  parameter int X_MIN         = 16,
  parameter int X_MAX         = 623,
  parameter int FLOOR_STEP    = 64,
  parameter int Y_MAX         = 460,
  parameter int HALF_BOX      = 8,
  parameter int START_LIVES   = 3,
  parameter int INVULN_FRAMES = 120
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       frame_tick,
  input  logic                       restart,
  input  logic [COORD_W-1:0]         PlayerX,
  input  logic [COORD_W-1:0]         PlayerY,
  output logic [N_SLOTS*COORD_W-1:0] SlotX,
  output logic [N_SLOTS*COORD_W-1:0] SlotY,
  output logic [N_SLOTS-1:0]         active,
  output logic [LIVES_W-1:0]         lives,
  output logic                       colliding,
  output logic                       hit,
  output logic                       invuln,
  output logic                       game_over,
  output logic                       spawn_overflow
);

  dmg_state_t           state;
  dmg_state_t           state_next;
  logic [LIVES_W-1:0]   lives_next;
  logic [15:0]          inv_cnt;
  logic [15:0]          inv_next;
  logic                 hit_next;
  logic [15:0]          spawn_cnt;
  logic                 rearm;
  logic                 clear;
  logic                 step;
  logic                 wrap;
  logic                 found;
  logic [N_SLOTS-1:0]   spawn_load;
  logic [N_SLOTS-1:0]   overlap;
  logic [COORD_W-1:0]   slot_x [N_SLOTS];
  logic [COORD_W-1:0]   slot_y [N_SLOTS];

  // A restart only acts in game over, where ticks are already frozen, so a
  // coincident frame_tick is discarded automatically.
  assign rearm = restart & game_over;
  assign clear = Reset | rearm;
  assign step  = frame_tick & ~game_over;
  assign wrap  = step && (spawn_cnt == 16'(SPAWN_PERIOD - 1));

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
    hazard_slot #(
      .SPAWN_X(SPAWN_X), .SPAWN_Y(SPAWN_Y), .SPEED(SPEED), .X_MIN(X_MIN),
      .X_MAX(X_MAX), .FLOOR_STEP(FLOOR_STEP), .Y_MAX(Y_MAX)
    ) u_slot (
      .clk        (Clk),
      .reset      (clear),
      .step       (step),
      .spawn_load (spawn_load[g]),
      .x          (slot_x[g]),
      .y          (slot_y[g]),
      .active     (active[g])
    );
  end

  // Lowest free slot (pre-tick mask) takes the spawn; overlap per slot.
  always_comb begin
    found      = 1'b0;
    spawn_load = '0;
    overlap    = '0;
    SlotX      = '0;
    SlotY      = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      spawn_load[i] = wrap & ~active[i] & ~found;
      found         = found | ~active[i];
      overlap[i]    = active[i] & axis_near(slot_x[i], PlayerX, HALF_BOX)
                                & axis_near(slot_y[i], PlayerY, HALF_BOX);
      SlotX[i*COORD_W +: COORD_W] = slot_x[i];
      SlotY[i*COORD_W +: COORD_W] = slot_y[i];
    end
  end

  // Damage controller: one life per tick at most, then an immunity window.
  always_comb begin
    state_next = state;
    lives_next = lives;
    inv_next   = inv_cnt;
    hit_next   = 1'b0;
    case (state)
      DMG_ARMED: begin
        if (step && colliding) begin
          lives_next = lives - 3'd1;
          hit_next   = 1'b1;
          inv_next   = 16'(INVULN_FRAMES);
          if (lives == 3'd1) begin
            state_next = DMG_OVER;
          end else if (INVULN_FRAMES == 32'sd0) begin
            state_next = DMG_ARMED;
          end else begin
            state_next = DMG_IMMUNE;
          end
        end else begin
          state_next = DMG_ARMED;
        end
      end
      DMG_IMMUNE: begin
        if (step) begin
          inv_next = inv_cnt - 16'd1;
          if (inv_cnt == 16'd1) begin
            state_next = DMG_ARMED;
          end else begin
            state_next = DMG_IMMUNE;
          end
        end else begin
          state_next = DMG_IMMUNE;
        end
      end
      DMG_OVER: begin
        state_next = DMG_OVER;
      end
      default: begin
        state_next = DMG_ARMED;
      end
    endcase
  end

  // Damage, spawn counter and collision registers.
  always_ff @(posedge Clk) begin
    if (clear) begin
      state     <= DMG_ARMED;
      lives     <= LIVES_W'(START_LIVES);
      inv_cnt   <= 16'd0;
      hit       <= 1'b0;
      spawn_cnt <= 16'd0;
      colliding <= 1'b0;
    end else begin
      state     <= state_next;
      lives     <= lives_next;
      inv_cnt   <= inv_next;
      hit       <= hit_next;
      colliding <= |overlap;
      if (wrap) begin
        spawn_cnt <= 16'd0;
      end else if (step) begin
        spawn_cnt <= spawn_cnt + 16'd1;
      end else begin
        spawn_cnt <= spawn_cnt;
      end
    end
  end

  // Overflow survives a restart; only Reset clears it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      spawn_overflow <= 1'b0;
    end else if (wrap && !found) begin
      spawn_overflow <= 1'b1;
    end else begin
      spawn_overflow <= spawn_overflow;
    end
  end

  assign invuln    = (inv_cnt != 16'd0);
  assign game_over = (state == DMG_OVER);

endmodule
